mesh_router_xbar: RTL
=====================

Name: mesh_router_xbar

Overview:
- Parametrised 5-port mesh router crossbar: bottom, left, right, top, local.
- Routes whole packets from input FIFO heads to output FIFOs using XY (column-first) routing on a NET_W x NET_H mesh.
- Each output runs its own FSM: round-robin arbitration, whole-packet room check, then packet lock until the last word.
- Adds over the previous crossbar: local eject/inject port, fair arbitration, multi-word packet transfer, single-cycle push/pop, route-error flag.

Parameters:
- WIDTH, 10: flit width in bits.
- ADDR_W, 3: width of the size and room fields.
- ID, 0: this node's id. col = ID % NET_W, row = ID / NET_W.
- NET_W, 1: mesh columns.
- NET_H, 1: mesh rows.
- NPORT, 5 (localparam): port indices 0=bottom, 1=left, 2=right, 3=top, 4=local.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous reset, active-low.
- in_data  in  NPORT*WIDTH  head word of each input FIFO.
- in_size  in  NPORT*ADDR_W  words of the head packet present in each input FIFO; 0 = empty.
- in_dist  in  NPORT*(WIDTH-2)  destination node id of the head packet.
- in_pop  out  NPORT  one-cycle pop to each input FIFO.
- out_data  out  NPORT*WIDTH  word to each downstream FIFO.
- out_push  out  NPORT  one-cycle push to each downstream FIFO.
- out_room  in  NPORT*ADDR_W  free entries in each downstream FIFO.
- out_busy  out  NPORT  output FSM is in BUSY.
- route_err  out  1  sticky flag: an out-of-range destination was seen.

Behaviour:
- Route function, per input, combinational, dst = in_dist:
  - If dst >= NET_W*NET_H: route local and set route_err.
  - Else if dst col > own col: right. If dst col < own col: left.
  - Else if dst row > own row: bottom. If dst row < own row: top.
  - Else: local.
- Request: input i requests output o when in_size[i] != 0 and route(i) == o. Each input requests exactly one output, so inputs never conflict across outputs.
- Output FSM, per output:
  - States: IDLE, BUSY. Registers: owner (3 bits), remaining (ADDR_W bits), rr_ptr (3 bits).
  - IDLE: search requesters starting at (rr_ptr+1) mod NPORT. The first requester whose in_size <= out_room is granted.
  - A requester that fails the room check is skipped for this cycle; the search continues to the next index.
  - On grant: owner <= i, remaining <= in_size[i], rr_ptr <= i, go to BUSY. No push occurs in the grant cycle.
  - BUSY: if in_size[owner] != 0, transfer one word this cycle: out_push=1, out_data=in_data[owner], in_pop[owner]=1, remaining decrements.
  - If in_size[owner] == 0 in BUSY, stall: no push, no pop, stay BUSY.
  - When a word is transferred with remaining == 1, go to IDLE. The earliest next grant is the following cycle.
- Timing:
  - out_push, out_data and in_pop are combinational from the registered state plus input data.
  - in_pop[i] is the OR over outputs in BUSY that own i.
  - out_data = 0 when out_push = 0.
  - A packet of S words reaches the output S+1 cycles after its request is first granted. Back-to-back packets on one output lose one cycle each.
- Room is checked once per packet at grant. No per-word room check is made.
- Reset, rst_n=0 at a clock edge:
  - All FSMs go to IDLE; remaining=0; rr_ptr=NPORT-1, so the first search starts at port 0; route_err=0.
  - As a result, all pushes, pops and out_busy are 0 from the next cycle.
  - A packet in flight when reset is asserted is abandoned; no further pops are issued for it.
- route_err is set in any cycle where a requesting input has an out-of-range dst. It is held until reset.

Decomposition:
- mesh_router_pkg holds:
  - port index constants (BOTTOM=0, LEFT=1, RIGHT=2, TOP=3, LOCAL=4) and NPORT;
  - the output state enum (IDLE, BUSY);
  - a route function taking (dst, id, net_w, net_h) and returning a port index.
- One sub-module, rr_arbiter:
  - inputs: NPORT request bits, NPORT eligibility (room-ok) bits, rr_ptr;
  - outputs: grant_valid, grant_idx.
  - Instantiated once per output.

Test Plan:
- All tests use NET_W=3, NET_H=3, ID=4 (col 1, row 1).
- Reset: rst_n=0 while every input has size 2 and room 7 -> in_pop, out_push, out_busy, route_err all 0 in the following cycle.
- Basic transfer: input left(1) with size=2, dist=5, room[right]=7 -> grant at cycle t. out_push[2] and in_pop[1] are high in t+1 and t+2 with out_data=in_data[1]. Output right is IDLE at t+3.
- Routing:
  - dist=7 -> bottom; dist=1 -> top; dist=3 -> left; dist=4 -> local.
  - Each case is single-word and checked via the out_push index.
- Room gating: size=4 with room=3 -> no grant for 10 cycles. Raise room to 4 -> grant next edge, then 4 consecutive pushes.
- Fairness: inputs 0, 1 and 3 all with dist=5, size=1, held continuously -> grant order on output right is 0, 1, 3, 0, 1, 3.
- Errors and reset mid-packet:
  - dist=12 -> routed to local and route_err=1, still 1 after the input goes idle.
  - Reset asserted after word 2 of a 4-word packet -> no push or pop afterwards; route_err=0.

Source files
------------

// File: rtl/mesh_router_pkg.sv
// Shared definitions for the 5-port mesh router crossbar:
// port indices, output FSM states and the XY route function.
package mesh_router_pkg;

   localparam int NPORT = 5;

   localparam logic [2:0] BOTTOM = 3'd0;
   localparam logic [2:0] LEFT   = 3'd1;
   localparam logic [2:0] RIGHT  = 3'd2;
   localparam logic [2:0] TOP    = 3'd3;
   localparam logic [2:0] LOCAL  = 3'd4;

   typedef enum logic {
      IDLE,
      BUSY
   } out_state_t;

   // Column first, then row; unknown nodes are ejected locally.
   function automatic logic [2:0] route(
      input int dst,
      input int id,
      input int net_w,
      input int net_h
   );
      int dc;
      int dr;
      int oc;
      int orow;
      if (dst >= net_w * net_h) return LOCAL;
      dc   = dst % net_w;
      dr   = dst / net_w;
      oc   = id % net_w;
      orow = id / net_w;
      if (dc > oc) return RIGHT;
      if (dc < oc) return LEFT;
      if (dr > orow) return BOTTOM;
      if (dr < orow) return TOP;
      return LOCAL;
   endfunction

endpackage

// File: rtl/mesh_router_xbar_rr_arbiter.sv
// Round-robin picker: first requester with room, searching
// upward from the slot after the last grant.
module rr_arbiter
   import mesh_router_pkg::*;
(
   input  logic [NPORT-1:0] req,
   input  logic [NPORT-1:0] ok,
   input  logic [2:0]       ptr,
   output logic             grant_valid,
   output logic [2:0]       grant_idx
);

   int idx;

   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = 3'd0;
      idx         = 0;
      for (int k = 1; k <= NPORT; k++) begin
         idx = (int'(ptr) + k) % NPORT;
         if (!grant_valid && req[idx] && ok[idx]) begin
            grant_valid = 1'b1;
            grant_idx   = 3'(idx);
         end
      end
   end

endmodule

// File: rtl/mesh_router_xbar.sv
// 5-port XY mesh crossbar: per-output round-robin grant with
// whole-packet room check, then packet lock until the last word.
module mesh_router_xbar
   import mesh_router_pkg::*;
#(
   parameter int WIDTH  = 10,
   parameter int ADDR_W = 3,
   parameter int ID     = 0,
   parameter int NET_W  = 1,
   parameter int NET_H  = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NPORT*WIDTH-1:0]    in_data,
   input  logic [NPORT*ADDR_W-1:0]   in_size,
   input  logic [NPORT*(WIDTH-2)-1:0] in_dist,
   output logic [NPORT-1:0]          in_pop,
   output logic [NPORT*WIDTH-1:0]    out_data,
   output logic [NPORT-1:0]          out_push,
   input  logic [NPORT*ADDR_W-1:0]   out_room,
   output logic [NPORT-1:0]          out_busy,
   output logic                      route_err
);

   localparam int DW = WIDTH - 2;

   logic [ADDR_W-1:0] size_a   [NPORT];
   logic [WIDTH-1:0]  data_a   [NPORT];
   logic [2:0]        rt       [NPORT];
   logic [NPORT-1:0]  active;
   logic [NPORT-1:0]  bad;

   logic [NPORT-1:0]  req      [NPORT];
   logic [NPORT-1:0]  ok       [NPORT];
   logic [NPORT-1:0]  gv;
   logic [2:0]        gi       [NPORT];

   out_state_t        state    [NPORT];
   logic [2:0]        owner    [NPORT];
   logic [ADDR_W-1:0] remaining[NPORT];
   logic [2:0]        rr_ptr   [NPORT];

   logic [ADDR_W-1:0] own_size [NPORT];
   logic [WIDTH-1:0]  own_data [NPORT];
   logic [NPORT-1:0]  xfer;

   always_comb begin
      active = '0;
      bad    = '0;
      for (int i = 0; i < NPORT; i++) begin
         size_a[i] = in_size[i*ADDR_W +: ADDR_W];
         data_a[i] = in_data[i*WIDTH +: WIDTH];
         rt[i]     = route(int'(in_dist[i*DW +: DW]), ID, NET_W, NET_H);
         active[i] = size_a[i] != '0;
         bad[i]    = active[i] &&
                     (int'(in_dist[i*DW +: DW]) >= NET_W * NET_H);
      end
   end

   always_comb begin
      for (int o = 0; o < NPORT; o++) begin
         req[o] = '0;
         ok[o]  = '0;
         for (int i = 0; i < NPORT; i++) begin
            req[o][i] = active[i] && (rt[i] == 3'(o));
            ok[o][i]  = size_a[i] <= out_room[o*ADDR_W +: ADDR_W];
         end
      end
   end

   for (genvar o = 0; o < NPORT; o++) begin : g_arb
      rr_arbiter u_arb (
         .req        (req[o]),
         .ok         (ok[o]),
         .ptr        (rr_ptr[o]),
         .grant_valid(gv[o]),
         .grant_idx  (gi[o])
      );
   end

   // Datapath is purely combinational off the locked owner.
   always_comb begin
      in_pop   = '0;
      out_push = '0;
      out_busy = '0;
      out_data = '0;
      xfer     = '0;
      for (int o = 0; o < NPORT; o++) begin
         own_size[o] = '0;
         own_data[o] = '0;
         for (int i = 0; i < NPORT; i++) begin
            if (owner[o] == 3'(i)) begin
               own_size[o] = size_a[i];
               own_data[o] = data_a[i];
            end
         end
         out_busy[o] = state[o] == BUSY;
         xfer[o]     = out_busy[o] && (own_size[o] != '0);
         out_push[o] = xfer[o];
         if (xfer[o]) out_data[o*WIDTH +: WIDTH] = own_data[o];
         for (int i = 0; i < NPORT; i++) begin
            if (xfer[o] && owner[o] == 3'(i)) in_pop[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         route_err <= 1'b0;
         for (int o = 0; o < NPORT; o++) begin
            state[o]     <= IDLE;
            owner[o]     <= 3'd0;
            remaining[o] <= '0;
            rr_ptr[o]    <= 3'(NPORT - 1);
         end
      end else begin
         route_err <= route_err | (|bad);
         for (int o = 0; o < NPORT; o++) begin
            unique case (state[o])
               IDLE: begin
                  if (gv[o]) begin
                     owner[o]     <= gi[o];
                     remaining[o] <= size_a[gi[o]];
                     rr_ptr[o]    <= gi[o];
                     state[o]     <= BUSY;
                  end
               end
               BUSY: begin
                  if (xfer[o]) begin
                     remaining[o] <= remaining[o] - 1'b1;
                     if (remaining[o] == 1) state[o] <= IDLE;
                  end
               end
               default: state[o] <= IDLE;
            endcase
         end
      end
   end

endmodule
